// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage constants and state encoding
package mips_pkg;

    localparam logic [1:0] RESET_WAIT = 2'd0;
    localparam logic [1:0] FETCH      = 2'd1;
    localparam logic [1:0] HOLD       = 2'd2;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = RESET_WAIT,
        ST_FETCH      = FETCH,
        ST_HOLD       = HOLD
    } fetch_state_e;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - sequential and branch-target next-PC selection
module fetch_pc_next (
    input  logic [31:0] pc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] imm_ext,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next
);

    logic [31:0] branch_target;

    // Word-offset branch relative to the following instruction; all sums wrap mod 2^32.
    always_comb begin
        pc_plus4      = pc + 32'd4;
        branch_target = pc_plus4 + (imm_ext << 2);
        pc_next       = (Branch && Zero) ? branch_target : pc_plus4;
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: PC, imem handshake, instruction register
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] imm_ext,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  Op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count
);

    fetch_state_e state;
    fetch_state_e state_next;
    logic         load_instr;
    logic         retire;
    logic [31:0]  pc_next;

    fetch_pc_next u_pc_next (
        .pc       (pc),
        .Branch   (Branch),
        .Zero     (Zero),
        .imm_ext  (imm_ext),
        .pc_plus4 (pc_plus4),
        .pc_next  (pc_next)
    );

    assign imem_addr = pc;
    assign Op        = instr[OP_MSB:OP_LSB];

    // Next-state logic: responses only count in FETCH, retirement only in HOLD without stall.
    always_comb begin
        state_next = state;
        load_instr = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_RESET_WAIT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_RESET_WAIT;
            end
        endcase
    end

    // State, PC, instruction register and retire counter; request is registered off next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET_WAIT;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            instr_count <= 32'd0;
            imem_req    <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next == ST_FETCH);
            if (load_instr) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= pc_next;
                instr_valid <= 1'b0;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] PC_A = 32'h0000_0000;
    localparam logic [31:0] PC_B = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_rvalid;
    logic        stall;
    logic        Branch;
    logic        Zero;
    logic [31:0] imm_ext;
    logic [31:0] junk_a, junk_b;

    logic        a_req, b_req;
    logic [31:0] a_addr, b_addr, a_rdata, b_rdata;
    logic [31:0] a_instr, b_instr;
    logic        a_valid, b_valid;
    logic [5:0]  a_op, b_op;
    logic [31:0] a_pc, b_pc, a_pp4, b_pp4, a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8C01_0004 ^ (a * 32'h9E37_79B1);
    endfunction

    assign a_rdata = imem_rvalid ? mem_word(a_addr) : junk_a;
    assign b_rdata = imem_rvalid ? mem_word(b_addr) : junk_b;

    instruction_fetch #(.RESET_PC(PC_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_req(a_req), .imem_addr(a_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(a_rdata), .stall(stall),
        .Branch(Branch), .Zero(Zero), .imm_ext(imm_ext), .instr(a_instr),
        .instr_valid(a_valid), .Op(a_op), .pc(a_pc), .pc_plus4(a_pp4),
        .instr_count(a_cnt)
    );

    instruction_fetch #(.RESET_PC(PC_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(b_rdata), .stall(stall),
        .Branch(Branch), .Zero(Zero), .imm_ext(imm_ext), .instr(b_instr),
        .instr_valid(b_valid), .Op(b_op), .pc(b_pc), .pc_plus4(b_pp4),
        .instr_count(b_cnt)
    );

    // Behavioural model: started / holding-an-instruction flags and per-instance PC.
    logic        m_started = 1'b0;
    logic        m_valid   = 1'b0;
    logic        m_req     = 1'b0;
    logic [31:0] m_pc [2]  = '{PC_A, PC_B};
    logic [31:0] m_instr [2] = '{32'd0, 32'd0};
    logic [31:0] m_count   = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 1'b0;
            m_valid   = 1'b0;
            m_pc[0]   = PC_A;
            m_pc[1]   = PC_B;
            m_instr[0] = 32'd0;
            m_instr[1] = 32'd0;
            m_count   = 32'd0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_valid) begin
            if (imem_rvalid) begin
                for (int k = 0; k < 2; k++) m_instr[k] = mem_word(m_pc[k]);
                m_valid = 1'b1;
            end
        end else if (!stall) begin
            for (int k = 0; k < 2; k++)
                m_pc[k] = m_pc[k] + 32'd4 + ((Branch && Zero) ? imm_ext * 32'd4 : 32'd0);
            m_valid = 1'b0;
            m_count = m_count + 32'd1;
        end
        m_req = m_started && !m_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string p, input logic req, input logic [31:0] addr,
                              input logic [31:0] ins, input logic vld, input logic [5:0] op,
                              input logic [31:0] pcv, input logic [31:0] pp4,
                              input logic [31:0] cnt, input int k);
        check({p, "_req"},   {31'd0, req}, {31'd0, m_req});
        check({p, "_addr"},  addr, m_pc[k]);
        check({p, "_instr"}, ins, m_instr[k]);
        check({p, "_valid"}, {31'd0, vld}, {31'd0, m_valid});
        check({p, "_op"},    {26'd0, op}, {26'd0, m_instr[k][31:26]});
        check({p, "_pc"},    pcv, m_pc[k]);
        check({p, "_pc_plus4"}, pp4, m_pc[k] + 32'd4);
        check({p, "_count"}, cnt, m_count);
    endtask

    task automatic compare_all();
        check_inst("a", a_req, a_addr, a_instr, a_valid, a_op, a_pc, a_pp4, a_cnt, 0);
        check_inst("b", b_req, b_addr, b_instr, b_valid, b_op, b_pc, b_pp4, b_cnt, 1);
    endtask

    task automatic step(input logic rv, input logic st, input logic br, input logic zr,
                        input logic [31:0] imm);
        imem_rvalid = rv;
        stall       = st;
        Branch      = br;
        Zero        = zr;
        imm_ext     = imm;
        junk_a      = $urandom;
        junk_b      = $urandom;
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_pc"},    a_pc, PC_A);
        check({tag, "_a_instr"}, a_instr, 32'd0);
        check({tag, "_a_valid"}, {31'd0, a_valid}, 32'd0);
        check({tag, "_a_count"}, a_cnt, 32'd0);
        check({tag, "_a_req"},   {31'd0, a_req}, 32'd0);
        check({tag, "_a_op"},    {26'd0, a_op}, 32'd0);
        check({tag, "_a_pp4"},   a_pp4, 32'd4);
        check({tag, "_b_pp4"},   b_pp4, 32'd0);
        check({tag, "_b_addr"},  b_addr, 32'hFFFF_FFFC);
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset held with a toggling response.
        for (int i = 0; i < 4; i++) step(i[0], 1'b0, 1'b0, 1'b0, 32'd0);
        check_reset_values("rst");

        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("rel_req", {31'd0, a_req}, 32'd1);
        check("rel_addr", a_addr, 32'd0);

        // Sequential fetch, zero-wait memory.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("seq_op", {26'd0, a_op}, {26'd0, 6'b100011});
        check("seq_instr", a_instr, 32'h8C01_0004);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("seq_pc4", a_pc, 32'd4);
        check("wrap_b_addr", b_addr, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("seq_pc8", a_pc, 32'd8);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("seq_count3", a_cnt, 32'd3);

        // Branch taken / not taken from pc 0x10.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("pc_10", a_pc, 32'h10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        check("br_taken", a_addr, 32'h0C);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
        check("br_not_taken", a_addr, 32'h14);
        check("wait_req0", {31'd0, a_req}, 32'd1);

        // Three memory wait cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
            check("wait_req", {31'd0, a_req}, 32'd1);
            check("wait_addr", a_addr, 32'h14);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("wait_valid", {31'd0, a_valid}, 32'd1);

        // Stall in HOLD with a stray response.
        for (int i = 0; i < 5; i++) begin
            step(i == 2, 1'b1, 1'b1, 1'b1, 32'h100);
            check("stall_pc", a_pc, 32'h14);
            check("stall_count", a_cnt, 32'd7);
            check("stall_instr", a_instr, mem_word(32'h14));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("post_stall_pc", a_pc, 32'h18);

        // Reset during FETCH with a response pending.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        imem_rvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("midrst_req", {31'd0, a_req}, 32'd1);
        check("midrst_instr", a_instr, 32'd0);
        check("midrst_valid", {31'd0, a_valid}, 32'd0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 63)) - 32'd32);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
